// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and TX state encoding for the APB UART front-end.
package apb_uart_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_TXDATA   = 8'h08;
    localparam logic [7:0] REG_RXDATA   = 8'h0C;
    localparam logic [7:0] REG_BAUD     = 8'h10;
    localparam logic [7:0] REG_IRQ_EN   = 8'h14;
    localparam logic [7:0] REG_IRQ_STAT = 8'h18;
    localparam logic [7:0] REG_LEVELS   = 8'h1C;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_TX_FLUSH = 2;
    localparam int unsigned CTRL_RX_FLUSH = 3;
    localparam int unsigned CTRL_THR_LSB  = 8;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_FULL    = 2;
    localparam int unsigned ST_RX_EMPTY   = 3;
    localparam int unsigned ST_TX_BUSY    = 4;
    localparam int unsigned ST_FSM_ACTIVE = 5;

    localparam int unsigned IRQ_RX_AVAIL = 0;
    localparam int unsigned IRQ_TX_EMPTY = 1;
    localparam int unsigned IRQ_RX_OVR   = 2;
    localparam int unsigned IRQ_RX_ERR   = 3;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; flush overrides push/pop, push into a full FIFO is allowed when popping.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (!flush && do_push) mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 zero-wait-state front-end for the UART cores: register file, TX/RX FIFOs,
// autonomous TX drain FSM, RX capture with overrun/error flags and a maskable IRQ.
module apb_uart_fifo
    import apb_uart_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned BAUD_RST = 868,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       baud_div,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rx_error,
    output logic              rx_reset,
    output logic              irq
);
    logic access, wr_acc, rd_acc, err;
    logic [ADDR_W-1:0] addr_word;
    logic [31:0] rdata;

    logic tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [3:0] rx_thr_q, rx_thr_d, irq_en_q, irq_en_d, w1c, irq_stat, rx_thr_eff;
    logic [31:0] baud_q, baud_d;
    logic rx_ovr_q, rx_ovr_d, rx_err_q, rx_err_d, irq_q, irq_d, rx_reset_q, rx_reset_d;

    logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_flush, rx_full, rx_empty, rx_take, rx_avail;
    logic [DATA_W-1:0] tx_dout, rx_dout;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;

    tx_state_e state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic tx_start_q;

    assign access    = psel & penable;
    assign wr_acc    = access & pwrite;
    assign rd_acc    = access & ~pwrite;
    assign addr_word = paddr & ~ADDR_W'(3);

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(pwdata[DATA_W-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_data), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign rx_thr_eff = (rx_thr_q == '0) ? 4'd1 : rx_thr_q;
    assign rx_avail   = (32'(rx_count) >= 32'(rx_thr_eff));

    always_comb begin
        irq_stat = '0;
        irq_stat[IRQ_RX_AVAIL] = rx_avail;
        irq_stat[IRQ_TX_EMPTY] = tx_empty;
        irq_stat[IRQ_RX_OVR]   = rx_ovr_q;
        irq_stat[IRQ_RX_ERR]   = rx_err_q;
    end

    // err is decoded for the current address/direction; side effects only fire on an error-free access
    always_comb begin
        rdata    = '0;
        err      = 1'b0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_flush = 1'b0;
        w1c      = '0;
        tx_en_d  = tx_en_q;
        rx_en_d  = rx_en_q;
        rx_thr_d = rx_thr_q;
        baud_d   = baud_q;
        irq_en_d = irq_en_q;
        case (addr_word)
            ADDR_W'(REG_CTRL): begin
                rdata[CTRL_TX_EN] = tx_en_q;
                rdata[CTRL_RX_EN] = rx_en_q;
                rdata[CTRL_THR_LSB +: 4] = rx_thr_q;
                if (wr_acc) begin
                    tx_en_d  = pwdata[CTRL_TX_EN];
                    rx_en_d  = pwdata[CTRL_RX_EN];
                    tx_flush = pwdata[CTRL_TX_FLUSH];
                    rx_flush = pwdata[CTRL_RX_FLUSH];
                    rx_thr_d = pwdata[CTRL_THR_LSB +: 4];
                end
            end
            ADDR_W'(REG_STATUS): begin
                err = pwrite;
                rdata[ST_TX_FULL]    = tx_full;
                rdata[ST_TX_EMPTY]   = tx_empty;
                rdata[ST_RX_FULL]    = rx_full;
                rdata[ST_RX_EMPTY]   = rx_empty;
                rdata[ST_TX_BUSY]    = tx_busy;
                rdata[ST_FSM_ACTIVE] = (state_q != IDLE);
            end
            ADDR_W'(REG_TXDATA): begin
                err     = pwrite & tx_full;
                tx_push = wr_acc & ~tx_full;
            end
            ADDR_W'(REG_RXDATA): begin
                err    = pwrite | rx_empty;
                rdata  = rx_empty ? '0 : 32'(rx_dout);
                rx_pop = rd_acc & ~rx_empty;
            end
            ADDR_W'(REG_BAUD): begin
                rdata = baud_q;
                if (wr_acc) baud_d = pwdata;
            end
            ADDR_W'(REG_IRQ_EN): begin
                rdata[3:0] = irq_en_q;
                if (wr_acc) irq_en_d = pwdata[3:0];
            end
            ADDR_W'(REG_IRQ_STAT): begin
                rdata[3:0] = irq_stat;
                if (wr_acc) w1c = pwdata[3:0];
            end
            ADDR_W'(REG_LEVELS): begin
                err = pwrite;
                rdata[15:0]  = 16'(tx_count);
                rdata[31:16] = 16'(rx_count);
            end
            default: err = 1'b1;
        endcase
    end

    assign rx_take    = rx_done & rx_en_q & ~rx_error;
    assign rx_push    = rx_take & (~rx_full | rx_pop);
    assign rx_ovr_d   = (rx_take & rx_full & ~rx_pop) | (rx_ovr_q & ~w1c[IRQ_RX_OVR]);
    assign rx_err_d   = (rx_done & rx_en_q & rx_error) | (rx_err_q & ~w1c[IRQ_RX_ERR]);
    assign irq_d      = |(irq_stat & irq_en_q);
    assign rx_reset_d = rx_flush;
    assign tx_pop     = (state_q == LOAD) & ~tx_empty;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            rx_thr_q   <= '0;
            baud_q     <= 32'(BAUD_RST);
            irq_en_q   <= '0;
            rx_ovr_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            irq_q      <= 1'b0;
            rx_reset_q <= 1'b0;
        end else begin
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            rx_thr_q   <= rx_thr_d;
            baud_q     <= baud_d;
            irq_en_q   <= irq_en_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_err_q   <= rx_err_d;
            irq_q      <= irq_d;
            rx_reset_q <= rx_reset_d;
        end
    end

    // LOAD re-checks emptiness because a flush may land between IDLE and LOAD
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: if (tx_en_q && !tx_empty) state_q <= LOAD;
                LOAD: begin
                    if (!tx_empty) begin
                        tx_data_q  <= tx_dout;
                        tx_start_q <= 1'b1;
                        state_q    <= WAIT_DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_DONE: if (tx_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata   = rd_acc ? rdata : '0;
    assign pready   = access;
    assign pslverr  = access & err;
    assign baud_div = baud_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign rx_reset = rx_reset_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo with a simple TX-core responder.
module tb_apb_uart_fifo;
    logic        pclk = 1'b0;
    logic        rst;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata, baud_div;
    logic        pready, pslverr, tx_start, tx_busy, tx_done;
    logic [7:0]  tx_data, rx_data;
    logic        rx_done, rx_error, rx_reset, irq;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned start_cnt = 0;
    int unsigned timer = 0;
    logic        model_en = 1'b1;
    logic [7:0]  cap[$];
    logic [31:0] last_rd;
    logic        last_err;

    always #5 pclk = ~pclk;

    apb_uart_fifo #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .BAUD_RST(868), .ADDR_W(8)) dut (
        .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr), .baud_div(baud_div),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error), .rx_reset(rx_reset), .irq(irq)
    );

    // TX core stand-in: logs every start and answers with tx_done 20 cycles later
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge pclk);
            tx_done = 1'b0;
            if (tx_start) begin
                start_cnt++;
                cap.push_back(tx_data);
                if (model_en) timer = 20;
            end else if (timer != 0) begin
                timer--;
                if (timer == 0) tx_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        last_rd  = prdata;
        last_err = pslverr;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic e);
        @(negedge pclk);
        rx_data = d; rx_done = 1'b1; rx_error = e;
        @(negedge pclk);
        rx_done = 1'b0; rx_error = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        tx_busy = 1'b0; rx_data = '0; rx_done = 1'b0; rx_error = 1'b0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);

        // reset state
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_baud_div", baud_div, 32'd868);
        apb(1'b0, 8'h10, '0);  chk("rst_baud_rd", last_rd, 32'd868);
        apb(1'b0, 8'h04, '0);  chk("rst_status", last_rd, 32'h0000000A);
        chk("rst_no_start", start_cnt, 32'd0);
        apb(1'b1, 8'h10, 32'h1234);
        chk("baud_wr", baud_div, 32'h1234);
        apb(1'b0, 8'h22, '0);  chk("unmapped_err", 32'(last_err), 32'd1);
        apb(1'b1, 8'h04, 32'hFF); chk("status_wr_err", 32'(last_err), 32'd1);

        // TX drain of three characters
        apb(1'b1, 8'h00, 32'h1);
        apb(1'b1, 8'h08, 32'h41);
        apb(1'b1, 8'h08, 32'h42);
        apb(1'b1, 8'h08, 32'h43);
        for (int i = 0; i < 400 && !(start_cnt == 3 && timer == 0 && !tx_done); i++) @(negedge pclk);
        repeat (3) @(negedge pclk);
        chk("tx_start_count", start_cnt, 32'd3);
        chk("tx_char0", (cap.size() > 0) ? 32'(cap[0]) : 32'hDEAD, 32'h41);
        chk("tx_char1", (cap.size() > 1) ? 32'(cap[1]) : 32'hDEAD, 32'h42);
        chk("tx_char2", (cap.size() > 2) ? 32'(cap[2]) : 32'hDEAD, 32'h43);
        apb(1'b0, 8'h1C, '0);  chk("tx_levels_drained", last_rd, 32'h0);
        apb(1'b0, 8'h18, '0);  chk("irqstat_tx_empty", last_rd, 32'h2);

        // TX FIFO overflow with transmitter disabled
        apb(1'b1, 8'h00, 32'h0);
        for (int i = 0; i < 16; i++) begin
            apb(1'b1, 8'h08, 32'(i));
            if (i == 15) chk("tx_16th_ok", 32'(last_err), 32'd0);
        end
        apb(1'b1, 8'h08, 32'hEE); chk("tx_17th_err", 32'(last_err), 32'd1);
        apb(1'b0, 8'h1C, '0);  chk("tx_levels_full", last_rd, 32'd16);
        apb(1'b0, 8'h04, '0);  chk("status_tx_full", last_rd, 32'h9);
        apb(1'b1, 8'h00, 32'h4);
        apb(1'b0, 8'h1C, '0);  chk("tx_flushed", last_rd, 32'h0);
        chk("no_start_disabled", start_cnt, 32'd3);

        // RX overrun and drain
        apb(1'b1, 8'h00, 32'h2);
        for (int i = 0; i < 17; i++) rx_pulse(8'(i), 1'b0);
        apb(1'b0, 8'h18, '0);  chk("irqstat_ovr", last_rd, 32'h7);
        apb(1'b0, 8'h1C, '0);  chk("rx_levels_full", last_rd, 32'h00100000);
        for (int i = 0; i < 16; i++) begin
            apb(1'b0, 8'h0C, '0);
            chk($sformatf("rx_pop%0d", i), {last_rd[30:0], last_err}, {31'(i), 1'b0});
        end
        apb(1'b0, 8'h0C, '0);
        chk("rx_empty_err", 32'(last_err), 32'd1);
        chk("rx_empty_data", last_rd, 32'd0);
        apb(1'b1, 8'h18, 32'h4);
        apb(1'b0, 8'h18, '0);  chk("ovr_w1c", last_rd, 32'h2);

        // RX threshold interrupt
        apb(1'b1, 8'h00, 32'h402);
        apb(1'b1, 8'h14, 32'h1);
        for (int i = 0; i < 3; i++) rx_pulse(8'hA0 + 8'(i), 1'b0);
        chk("irq_below_thr", 32'(irq), 32'd0);
        rx_pulse(8'hA3, 1'b0);
        chk("irq_latency", 32'(irq), 32'd0);
        @(negedge pclk);
        chk("irq_rise", 32'(irq), 32'd1);
        apb(1'b0, 8'h0C, '0);  chk("rx_thr_pop", last_rd, 32'hA0);
        @(negedge pclk);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge pclk);
        chk("irq_fall", 32'(irq), 32'd0);

        // RX error flag and W1C, then RX flush
        rx_pulse(8'h55, 1'b1);
        apb(1'b0, 8'h1C, '0);  chk("rx_err_count", last_rd, 32'h00030000);
        apb(1'b0, 8'h18, '0);  chk("irqstat_err", last_rd, 32'hA);
        apb(1'b1, 8'h18, 32'h8);
        apb(1'b0, 8'h18, '0);  chk("err_w1c", last_rd, 32'h2);
        apb(1'b1, 8'h00, 32'h40A);
        chk("rx_reset_pulse", 32'(rx_reset), 32'd1);
        @(posedge pclk); #1;
        chk("rx_reset_end", 32'(rx_reset), 32'd0);
        apb(1'b0, 8'h1C, '0);  chk("rx_flushed", last_rd, 32'h0);

        // reset while waiting for tx_done
        model_en = 1'b0;
        apb(1'b1, 8'h00, 32'h1);
        apb(1'b1, 8'h08, 32'h5A);
        apb(1'b1, 8'h08, 32'h5B);
        for (int i = 0; i < 50 && start_cnt < 4; i++) @(negedge pclk);
        chk("wait_start", start_cnt, 32'd4);
        chk("wait_tx_data", 32'(tx_data), 32'h5A);
        apb(1'b0, 8'h04, '0);  chk("status_active", last_rd, 32'h28);
        @(negedge pclk);
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        repeat (30) @(negedge pclk);
        chk("rst_no_retry", start_cnt, 32'd4);
        chk("rst_baud_restore", baud_div, 32'd868);
        apb(1'b0, 8'h04, '0);  chk("rst_status_idle", last_rd, 32'h0000000A);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
